// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative divide/remainder unit.
//   divfunc_t   : the eight RV64M divide/remainder operations
//   div_state_t : control states of the divider
//   div_op_t    : decoded operation flags (W width, signedness, remainder select)
//   DIV_STEPS64 / DIV_STEPS32 : restoring steps for full-width and W operations
package divider_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [2:0] {
    DIV   = 3'd0,
    DIVU  = 3'd1,
    REM   = 3'd2,
    REMU  = 3'd3,
    DIVW  = 3'd4,
    DIVUW = 3'd5,
    REMW  = 3'd6,
    REMUW = 3'd7
  } divfunc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic is_w;
    logic is_signed;
    logic is_rem;
  } div_op_t;

  localparam int unsigned DIV_STEPS64 = 64;
  localparam int unsigned DIV_STEPS32 = 32;

  // Any encoding not named below behaves as DIVU.
  function automatic div_op_t decode_op(input divfunc_t f);
    div_op_t o;
    o = '{is_w: 1'b0, is_signed: 1'b0, is_rem: 1'b0};
    case (f)
      DIV:     o.is_signed = 1'b1;
      REM:     begin o.is_signed = 1'b1; o.is_rem = 1'b1; end
      REMU:    o.is_rem = 1'b1;
      DIVW:    begin o.is_w = 1'b1; o.is_signed = 1'b1; end
      DIVUW:   o.is_w = 1'b1;
      REMW:    begin o.is_w = 1'b1; o.is_signed = 1'b1; o.is_rem = 1'b1; end
      REMUW:   begin o.is_w = 1'b1; o.is_rem = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response handshake between the execute stage and the divider.
//   in_valid/in_ready   : operand handshake (a, b, divfunc)
//   out_valid/out_ready : result handshake (c)
// master = execute stage, slave = divider.
interface divider_if
  import divider_pkg::*;
#(
  parameter int unsigned XLEN = 64
) ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  divfunc_t        divfunc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] c;

  modport master (
    output in_valid, a, b, divfunc, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, divfunc, out_ready,
    output in_ready, out_valid, c
  );

endinterface

// File: rtl/divider_div_step.sv
// One combinational radix-2 restoring division step.
//   rem_i, quo_i : partial remainder and dividend/quotient shift register
//   divisor_i    : divisor magnitude
//   rem_o, quo_o : values after shifting one dividend bit into the remainder
//                  and appending the new quotient bit
module div_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    fits    = (shifted >= {1'b0, divisor_i});
    rem_o   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/divider.sv
// Iterative restoring divide/remainder unit for RV64M DIV/DIVU/REM/REMU and
// their W forms. One operation in flight; the result is held until consumed.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   flush  : abandon any in-flight operation or pending result
//   io     : divider_if slave (operands in, result out)
module divider
  import divider_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     flush,
  divider_if.slave io
);

  localparam int unsigned CW = $clog2(DIV_STEPS64);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  // Most-negative 32-bit value after sign extension to XLEN.
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] c_q, c_d;
  logic            is_w_q, is_w_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_q, neg_d;

  // Operand decode at accept time.
  div_op_t         op;
  logic [XLEN-1:0] opa, opb, mag_a, mag_b, special_c;
  logic            neg_a, neg_b, b_zero, ovf, special, accept;

  always_comb begin
    op      = decode_op(io.divfunc);
    opa     = op.is_w ? (op.is_signed ? {{(XLEN-32){io.a[31]}}, io.a[31:0]}
                                      : {{(XLEN-32){1'b0}}, io.a[31:0]}) : io.a;
    opb     = op.is_w ? (op.is_signed ? {{(XLEN-32){io.b[31]}}, io.b[31:0]}
                                      : {{(XLEN-32){1'b0}}, io.b[31:0]}) : io.b;
    neg_a   = op.is_signed & opa[XLEN-1];
    neg_b   = op.is_signed & opb[XLEN-1];
    mag_a   = neg_a ? ('0 - opa) : opa;
    mag_b   = neg_b ? ('0 - opb) : opb;
    b_zero  = (opb == '0);
    ovf     = op.is_signed & (opa == (op.is_w ? MIN_W : MIN_X)) & (opb == '1);
    special = b_zero | ovf;
    if (b_zero) special_c = op.is_rem ? opa : '1;
    else        special_c = op.is_rem ? '0 : opa;
    special_c = fix_w(special_c, op.is_w);
    accept  = (state_q == ST_IDLE) & io.in_valid & ~flush;
  end

  // Iteration datapath.
  logic [XLEN-1:0] step_rem, step_quo, raw, fin;
  logic            run_last;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    run_last = (state_q == ST_RUN) &&
               (cnt_q == (is_w_q ? CW'(DIV_STEPS32 - 1) : CW'(DIV_STEPS64 - 1)));
    raw      = is_rem_q ? step_rem : step_quo;
    fin      = fix_w(neg_q ? ('0 - raw) : raw, is_w_q);
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state. flush wins over every other request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_RUN;
      ST_RUN:  if (flush) state_d = ST_IDLE;
               else if (run_last) state_d = ST_DONE;
      ST_DONE: if (flush || io.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: io.in_ready  = 1'b1;
      ST_DONE: io.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign io.c = c_q;

  // Datapath next state.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    c_d      = c_q;
    is_w_d   = is_w_q;
    is_rem_d = is_rem_q;
    neg_d    = neg_q;
    if (accept) begin
      cnt_d    = '0;
      rem_d    = '0;
      // W dividends sit in the upper half so 32 shifts consume them and the
      // quotient ends up in the low half.
      quo_d    = op.is_w ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
      div_d    = mag_b;
      is_w_d   = op.is_w;
      is_rem_d = op.is_rem;
      neg_d    = op.is_rem ? neg_a : (neg_a ^ neg_b);
      if (special) c_d = special_c;
    end else if (state_q == ST_RUN && !flush) begin
      cnt_d = cnt_q + 1'b1;
      rem_d = step_rem;
      quo_d = step_quo;
      if (run_last) c_d = fin;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      c_q      <= '0;
      is_w_q   <= 1'b0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      c_q      <= c_d;
      is_w_q   <= is_w_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, hand-written
// handshake/flush/reset sequences, and random operations checked against an
// arithmetic reference model. Latency is counted in clock edges after the
// accept edge (0 means the result is visible right after the accept edge).
module tb_divider;
  import divider_pkg::*;

  typedef struct {
    divfunc_t f;
    u64       a;
    u64       b;
    u64       c;
    int       lat;
    int       hold;
    string    nm;
  } vec_t;

  logic clk;
  logic resetn;
  logic flush;
  int   n_cmp;
  int   n_bad;

  divider_if #(.XLEN(64)) dif ();

  divider #(.XLEN(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .io     (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input u64 act, input u64 exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic u64 model(input divfunc_t f, input u64 a, input u64 b);
    bit w, sgn, rm;
    u32 a32, b32, r32;
    u64 r;
    w   = f inside {DIVW, DIVUW, REMW, REMUW};
    sgn = f inside {DIV, REM, DIVW, REMW};
    rm  = f inside {REM, REMU, REMW, REMUW};
    if (!w) begin
      if (b == 0) r = rm ? a : '1;
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) r = rm ? '0 : a;
      else if (sgn) r = rm ? u64'(longint'(a) % longint'(b)) : u64'(longint'(a) / longint'(b));
      else r = rm ? a % b : a / b;
    end else begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) r32 = rm ? a32 : '1;
      else if (sgn && a32 == 32'h8000_0000 && b32 == '1) r32 = rm ? '0 : a32;
      else if (sgn) r32 = rm ? u32'(int'(a32) % int'(b32)) : u32'(int'(a32) / int'(b32));
      else r32 = rm ? a32 % b32 : a32 / b32;
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic int model_lat(input divfunc_t f, input u64 a, input u64 b);
    bit w, sgn;
    w   = f inside {DIVW, DIVUW, REMW, REMUW};
    sgn = f inside {DIV, REM, DIVW, REMW};
    if (w) begin
      if (b[31:0] == 0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == '1)) return 0;
      return 32;
    end
    if (b == 0 || (sgn && a == 64'h8000_0000_0000_0000 && b == '1)) return 0;
    return 64;
  endfunction

  // Issue one op, measure latency, optionally stall the consumer, then hand off.
  task automatic run_op(input divfunc_t f, input u64 a, input u64 b, input u64 exp_c,
                        input int exp_lat, input int hold, input string nm);
    int w;
    int lat;
    w = 0;
    while (!dif.in_ready && w < 8) begin tick(); w++; end
    check({nm, "_ready"}, u64'(dif.in_ready), 64'd1);
    dif.divfunc  = f;
    dif.a        = a;
    dif.b        = b;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    lat = 0;
    while (!dif.out_valid && lat < 100) begin tick(); lat++; end
    check({nm, "_lat"}, u64'(lat), u64'(exp_lat));
    check({nm, "_c"}, dif.c, exp_c);
    for (int h = 0; h < hold; h++) begin
      dif.in_valid = 1'b1;
      dif.a        = ~a;
      tick();
      check($sformatf("%s_hold%0d_c", nm, h), dif.c, exp_c);
      check($sformatf("%s_hold%0d_ov", nm, h), u64'(dif.out_valid), 64'd1);
      check($sformatf("%s_hold%0d_ir", nm, h), u64'(dif.in_ready), 64'd0);
    end
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b0;
    check({nm, "_hand_ov"}, u64'(dif.out_valid), 64'd0);
    check({nm, "_hand_ir"}, u64'(dif.in_ready), 64'd1);
    check({nm, "_idle_c"}, dif.c, exp_c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    vecs[$];
    divfunc_t rf;
    u64      ra, rb;
    bit      seen;
    int      n;

    n_cmp = 0;
    n_bad = 0;
    resetn        = 1'b0;
    flush         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.a         = '0;
    dif.b         = '0;
    dif.divfunc   = DIVU;

    #12;
    check("reset_ir", u64'(dif.in_ready), 64'd1);
    check("reset_ov", u64'(dif.out_valid), 64'd0);
    check("reset_c", dif.c, 64'd0);
    #10 resetn = 1'b1;
    tick();

    vecs.push_back('{DIVU,  64'd100, 64'd7, 64'd14, 64, 5, "divu_100_7"});
    vecs.push_back('{REMU,  64'd100, 64'd7, 64'd2, 64, 0, "remu_100_7"});
    vecs.push_back('{DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0, "div_m7_2"});
    vecs.push_back('{REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0, "rem_m7_2"});
    vecs.push_back('{REM,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64, 0, "rem_7_m2"});
    vecs.push_back('{DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "div_by0"});
    vecs.push_back('{REMU,  64'd5, 64'd0, 64'd5, 0, 0, "remu_by0"});
    vecs.push_back('{DIV,   64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 0, "div_ovf"});
    vecs.push_back('{REM,   64'h8000_0000_0000_0000, '1, 64'd0, 0, 0, "rem_ovf"});
    vecs.push_back('{DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 32, 0, "divuw_sext"});
    vecs.push_back('{DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 0, "divw_ovf"});
    vecs.push_back('{REMW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 0, 0, "remw_ovf"});
    vecs.push_back('{REMUW, 64'h0000_0001_0000_0007, 64'h0000_0005_0000_0003, 64'd1, 32, 0, "remuw_low"});
    vecs.push_back('{DIVUW, 64'h0000_0000_FFFF_FFF0, 64'h1234_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "divuw_by0"});
    vecs.push_back('{REMW,  64'h0000_1234_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 0, 0, "remw_by0"});
    vecs.push_back('{DIVW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 0, "divw_m7_2"});
    vecs.push_back('{DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64, 0, "divu_big"});
    vecs.push_back('{REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 64, 1, "remu_big"});

    foreach (vecs[i])
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].lat, vecs[i].hold, vecs[i].nm);

    // Flush in the middle of an iteration: no result, previous c retained.
    run_op(DIVU, 64'd100, 64'd7, 64'd14, 64, 0, "pre_flush");
    dif.divfunc  = DIVU;
    dif.a        = 64'd1000;
    dif.b        = 64'd3;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    flush         = 1'b1;
    dif.out_ready = 1'b1;
    tick();
    flush         = 1'b0;
    dif.out_ready = 1'b0;
    check("flush_run_ir", u64'(dif.in_ready), 64'd1);
    check("flush_run_ov", u64'(dif.out_valid), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin tick(); seen |= dif.out_valid; end
    check("flush_run_never_valid", u64'(seen), 64'd0);
    check("flush_run_c_kept", dif.c, 64'd14);

    // Asynchronous reset in the middle of an iteration.
    dif.a        = 64'd1000;
    dif.b        = 64'd3;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    #2 resetn = 1'b0;
    #1;
    check("rst_run_c", dif.c, 64'd0);
    check("rst_run_ir", u64'(dif.in_ready), 64'd1);
    check("rst_run_ov", u64'(dif.out_valid), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 70; k++) begin tick(); seen |= dif.out_valid; end
    check("rst_run_never_valid", u64'(seen), 64'd0);

    // flush together with in_valid in IDLE: not accepted.
    dif.divfunc  = DIV;
    dif.a        = 64'd5;
    dif.b        = 64'd0;
    dif.in_valid = 1'b1;
    flush        = 1'b1;
    tick();
    flush        = 1'b0;
    dif.in_valid = 1'b0;
    check("flush_idle_ir", u64'(dif.in_ready), 64'd1);
    check("flush_idle_ov", u64'(dif.out_valid), 64'd0);

    // flush in DONE overrides a simultaneous out_ready; c unchanged.
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    check("flush_done_pre_ov", u64'(dif.out_valid), 64'd1);
    flush         = 1'b1;
    dif.out_ready = 1'b1;
    tick();
    flush         = 1'b0;
    dif.out_ready = 1'b0;
    check("flush_done_ov", u64'(dif.out_valid), 64'd0);
    check("flush_done_ir", u64'(dif.in_ready), 64'd1);
    check("flush_done_c", dif.c, 64'hFFFF_FFFF_FFFF_FFFF);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rf = divfunc_t'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = u64'($urandom_range(1, 20));
        3:       rb = {32'h0, $urandom};
        4:       begin ra = 64'h8000_0000_0000_0000; rb = '1; end
        5:       begin ra = {$urandom, 32'h8000_0000}; rb = {$urandom, 32'hFFFF_FFFF}; end
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) ra = {32'h0, $urandom};
      n = $urandom_range(0, 3);
      run_op(rf, ra, rb, model(rf, ra, rb), model_lat(rf, ra, rb), n, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
